eeg_oram_bank_arb: RTL and testbench

//  Bank-side responder of the ORAM demux fabric: one instance per OMUX bank. Arbitrates the
//  per-master write (DAT) and read-address (ADD) requests routed to this bank onto a single-port

---
 rtl/eeg_oram_bank_arb.sv | 182 ++++++++++++++++++
 tb/tb_eeg_oram_bank_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeg_oram_bank_arb.sv
// Bank-side arbiter for one ORAM demux bank: round-robin over per-master write/read sources with
// burst lock, a single-port SRAM, and a 2-entry credit-gated read-return buffer.
module eeg_oram_bank_arb #(
  parameter int ORAM_NUM_DW = 4,
  parameter int OMUX_ADD_AW = 10,
  parameter int ORAM_DAT_DW = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ORAM_NUM_DW-1:0]             DMX_MTOO_DAT_VLD,
  input  logic [ORAM_NUM_DW-1:0]             DMX_MTOO_DAT_LST,
  output logic [ORAM_NUM_DW-1:0]             DMX_MTOO_DAT_RDY,
  input  logic [ORAM_NUM_DW*OMUX_ADD_AW-1:0] DMX_MTOO_DAT_ADD,
  input  logic [ORAM_NUM_DW*ORAM_DAT_DW-1:0] DMX_MTOO_DAT_DAT,
  input  logic [ORAM_NUM_DW-1:0]             DMX_MTOO_ADD_VLD,
  input  logic [ORAM_NUM_DW-1:0]             DMX_MTOO_ADD_LST,
  output logic [ORAM_NUM_DW-1:0]             DMX_MTOO_ADD_RDY,
  input  logic [ORAM_NUM_DW*OMUX_ADD_AW-1:0] DMX_MTOO_ADD_ADD,
  output logic [ORAM_NUM_DW-1:0]             DMX_OTOM_DAT_VLD,
  output logic [ORAM_NUM_DW-1:0]             DMX_OTOM_DAT_LST,
  input  logic [ORAM_NUM_DW-1:0]             DMX_OTOM_DAT_RDY,
  output logic [ORAM_NUM_DW*ORAM_DAT_DW-1:0] DMX_OTOM_DAT_DAT,
  output logic                               SRAM_CEN,
  output logic                               SRAM_WEN,
  output logic [OMUX_ADD_AW-1:0]             SRAM_ADD,
  output logic [ORAM_DAT_DW-1:0]             SRAM_DIN,
  input  logic [ORAM_DAT_DW-1:0]             SRAM_DOUT
);
  localparam int NS = 2 * ORAM_NUM_DW;
  localparam int SW = $clog2(NS);
  localparam int MW = SW - 1;

  typedef enum logic {ARB, LOCK} state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   ptr_reg, ptr_next, lock_src_reg, lock_src_next;
  logic            pend_reg, pend_lst_reg;
  logic [MW-1:0]   pend_tag_reg;
  logic            wr_ptr_reg, rd_ptr_reg;
  logic [1:0]      occ_reg;
  logic [ORAM_DAT_DW-1:0] fifo_dat [2];
  logic [MW-1:0]          fifo_tag [2];
  logic                   fifo_lst [2];

  logic [NS-1:0]   src_vld, src_lst, src_elig, rdy;
  logic [SW-1:0]   win, idx;
  logic            win_vld, blocked, credit, push, pop, fifo_nonempty;
  logic [MW-1:0]   win_mst, head_tag;
  logic            win_is_rd, win_lst;

  assign fifo_nonempty = (occ_reg != 2'd0);
  assign head_tag      = fifo_tag[rd_ptr_reg];
  assign pop           = fifo_nonempty && DMX_OTOM_DAT_RDY[head_tag];
  assign push          = pend_reg;
  // Counts buffered, in-flight and departing entries so the buffer can never overflow.
  assign credit = (({1'b0, occ_reg} + {2'b00, pend_reg} - {2'b00, pop}) < 3'd2);

  genvar gi;
  generate
    for (gi = 0; gi < ORAM_NUM_DW; gi++) begin : g_src
      assign src_vld[2*gi]    = DMX_MTOO_DAT_VLD[gi];
      assign src_vld[2*gi+1]  = DMX_MTOO_ADD_VLD[gi];
      assign src_lst[2*gi]    = DMX_MTOO_DAT_LST[gi];
      assign src_lst[2*gi+1]  = DMX_MTOO_ADD_LST[gi];
      assign src_elig[2*gi]   = 1'b1;
      assign src_elig[2*gi+1] = credit;
      assign DMX_MTOO_DAT_RDY[gi] = rdy[2*gi];
      assign DMX_MTOO_ADD_RDY[gi] = rdy[2*gi+1];
      assign DMX_OTOM_DAT_VLD[gi] = fifo_nonempty && (head_tag == MW'(gi));
      assign DMX_OTOM_DAT_LST[gi] = fifo_nonempty && (head_tag == MW'(gi)) && fifo_lst[rd_ptr_reg];
      assign DMX_OTOM_DAT_DAT[gi*ORAM_DAT_DW +: ORAM_DAT_DW] = fifo_dat[rd_ptr_reg];
    end
  endgenerate

  // RDY of a source does not depend on its own VLD: the demux ANDs RDY across banks.
  always_comb begin
    rdy     = '0;
    win     = '0;
    win_vld = 1'b0;
    blocked = 1'b0;
    idx     = '0;
    if (state_reg == LOCK) begin
      rdy[lock_src_reg] = src_elig[lock_src_reg];
      win               = lock_src_reg;
      win_vld           = src_vld[lock_src_reg] && src_elig[lock_src_reg];
    end else begin
      for (int k = 0; k < NS; k++) begin
        idx      = SW'((32'(ptr_reg) + 32'(k)) % NS);
        rdy[idx] = !blocked && src_elig[idx];
        if (!blocked && src_vld[idx] && src_elig[idx]) begin
          blocked = 1'b1;
          win     = idx;
          win_vld = 1'b1;
        end
      end
    end
    if (!rst_n) begin
      rdy     = '0;
      win_vld = 1'b0;
    end
  end

  assign win_mst   = win[SW-1:1];
  assign win_is_rd = win[0];
  assign win_lst   = src_lst[win];

  always_comb begin
    SRAM_CEN = 1'b1;
    SRAM_WEN = 1'b1;
    SRAM_ADD = '0;
    SRAM_DIN = '0;
    if (win_vld) begin
      SRAM_CEN = 1'b0;
      if (win_is_rd) begin
        SRAM_ADD = DMX_MTOO_ADD_ADD[win_mst*OMUX_ADD_AW +: OMUX_ADD_AW];
      end else begin
        SRAM_WEN = 1'b0;
        SRAM_ADD = DMX_MTOO_DAT_ADD[win_mst*OMUX_ADD_AW +: OMUX_ADD_AW];
        SRAM_DIN = DMX_MTOO_DAT_DAT[win_mst*ORAM_DAT_DW +: ORAM_DAT_DW];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    lock_src_next = lock_src_reg;
    if (win_vld) begin
      case (state_reg)
        ARB: begin
          ptr_next = (win == SW'(NS - 1)) ? '0 : win + 1'b1;
          if (!win_lst) begin
            state_next    = LOCK;
            lock_src_next = win;
          end
        end
        LOCK: if (win_lst) state_next = ARB;
        default: state_next = ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ARB;
      ptr_reg      <= '0;
      lock_src_reg <= '0;
      pend_reg     <= 1'b0;
      pend_tag_reg <= '0;
      pend_lst_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      lock_src_reg <= lock_src_next;
      pend_reg     <= win_vld && win_is_rd;
      pend_tag_reg <= win_mst;
      pend_lst_reg <= win_lst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
      for (int j = 0; j < 2; j++) begin
        fifo_dat[j] <= '0;
        fifo_tag[j] <= '0;
        fifo_lst[j] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_dat[wr_ptr_reg] <= SRAM_DOUT;
        fifo_tag[wr_ptr_reg] <= pend_tag_reg;
        fifo_lst[wr_ptr_reg] <= pend_lst_reg;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_eeg_oram_bank_arb.sv
// Randomized bench for eeg_oram_bank_arb against a queue-based model of the arbitration rules,
// an SRAM memory model and the in-order return buffer.
module tb_eeg_oram_bank_arb;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 4;
  localparam int NS = 2 * N;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    DMX_MTOO_DAT_VLD, DMX_MTOO_DAT_LST, DMX_MTOO_DAT_RDY;
  logic [N*AW-1:0] DMX_MTOO_DAT_ADD, DMX_MTOO_ADD_ADD;
  logic [N*DW-1:0] DMX_MTOO_DAT_DAT, DMX_OTOM_DAT_DAT;
  logic [N-1:0]    DMX_MTOO_ADD_VLD, DMX_MTOO_ADD_LST, DMX_MTOO_ADD_RDY;
  logic [N-1:0]    DMX_OTOM_DAT_VLD, DMX_OTOM_DAT_LST, DMX_OTOM_DAT_RDY;
  logic            SRAM_CEN, SRAM_WEN;
  logic [AW-1:0]   SRAM_ADD;
  logic [DW-1:0]   SRAM_DIN, SRAM_DOUT;

  int checks = 0;
  int errors = 0;

  eeg_oram_bank_arb #(.ORAM_NUM_DW(N), .OMUX_ADD_AW(AW), .ORAM_DAT_DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .DMX_MTOO_DAT_VLD(DMX_MTOO_DAT_VLD), .DMX_MTOO_DAT_LST(DMX_MTOO_DAT_LST),
    .DMX_MTOO_DAT_RDY(DMX_MTOO_DAT_RDY), .DMX_MTOO_DAT_ADD(DMX_MTOO_DAT_ADD),
    .DMX_MTOO_DAT_DAT(DMX_MTOO_DAT_DAT),
    .DMX_MTOO_ADD_VLD(DMX_MTOO_ADD_VLD), .DMX_MTOO_ADD_LST(DMX_MTOO_ADD_LST),
    .DMX_MTOO_ADD_RDY(DMX_MTOO_ADD_RDY), .DMX_MTOO_ADD_ADD(DMX_MTOO_ADD_ADD),
    .DMX_OTOM_DAT_VLD(DMX_OTOM_DAT_VLD), .DMX_OTOM_DAT_LST(DMX_OTOM_DAT_LST),
    .DMX_OTOM_DAT_RDY(DMX_OTOM_DAT_RDY), .DMX_OTOM_DAT_DAT(DMX_OTOM_DAT_DAT),
    .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN), .SRAM_ADD(SRAM_ADD),
    .SRAM_DIN(SRAM_DIN), .SRAM_DOUT(SRAM_DOUT)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            tag;
    bit            lst;
    logic [DW-1:0] dat;
  } ret_t;

  // Reference model state
  int            m_ptr;
  bit            m_lock;
  int            m_lsrc;
  bit            m_pend;
  int            m_ptag;
  bit            m_plst;
  logic [DW-1:0] m_pdat;
  ret_t          m_q[$];
  logic [DW-1:0] mem [1024];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_lock = 0;
    m_lsrc = 0;
    m_pend = 0;
    m_q.delete();
  endtask

  task automatic clear_inputs();
    DMX_MTOO_DAT_VLD = '0; DMX_MTOO_DAT_LST = '0; DMX_MTOO_DAT_ADD = '0; DMX_MTOO_DAT_DAT = '0;
    DMX_MTOO_ADD_VLD = '0; DMX_MTOO_ADD_LST = '0; DMX_MTOO_ADD_ADD = '0;
  endtask

  task automatic rand_inputs(input int rdy_pct);
    for (int i = 0; i < N; i++) begin
      DMX_MTOO_DAT_VLD[i] = ($urandom_range(0, 99) < 45);
      DMX_MTOO_DAT_LST[i] = $urandom_range(0, 1);
      DMX_MTOO_ADD_VLD[i] = ($urandom_range(0, 99) < 45);
      DMX_MTOO_ADD_LST[i] = $urandom_range(0, 1);
      DMX_MTOO_DAT_ADD[i*AW +: AW] = AW'($urandom_range(0, 15));
      DMX_MTOO_ADD_ADD[i*AW +: AW] = AW'($urandom_range(0, 15));
      DMX_MTOO_DAT_DAT[i*DW +: DW] = DW'($urandom);
      DMX_OTOM_DAT_RDY[i] = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, advances the model one clock.
  task automatic step(input string name);
    logic [NS-1:0]   v, l, e, exp_rdy;
    logic [N-1:0]    exp_drdy, exp_ardy, exp_ovld, exp_olst;
    logic [N*DW-1:0] exp_odat;
    logic [AW-1:0]   exp_add;
    logic [DW-1:0]   exp_din;
    int  occ, w, best, mst;
    bit  deq, credit, wv, rd;
    #4;
    occ    = m_q.size();
    deq    = (occ > 0) && DMX_OTOM_DAT_RDY[m_q[0].tag];
    credit = (occ + int'(m_pend) - int'(deq)) < 2;
    for (int i = 0; i < N; i++) begin
      v[2*i] = DMX_MTOO_DAT_VLD[i]; v[2*i+1] = DMX_MTOO_ADD_VLD[i];
      l[2*i] = DMX_MTOO_DAT_LST[i]; l[2*i+1] = DMX_MTOO_ADD_LST[i];
      e[2*i] = 1'b1;                e[2*i+1] = credit;
    end
    exp_rdy = '0;
    w = 0;
    wv = 0;
    if (m_lock) begin
      exp_rdy[m_lsrc] = e[m_lsrc];
      if (v[m_lsrc] && e[m_lsrc]) begin wv = 1; w = m_lsrc; end
    end else begin
      best = NS;
      for (int s = 0; s < NS; s++) begin
        int d;
        d = (s - m_ptr + NS) % NS;
        exp_rdy[s] = e[s];
        for (int j = 0; j < d; j++)
          if (v[(m_ptr + j) % NS] && e[(m_ptr + j) % NS]) exp_rdy[s] = 1'b0;
        if (v[s] && e[s] && d < best) begin best = d; w = s; end
      end
      wv = (best < NS);
    end
    for (int i = 0; i < N; i++) begin
      exp_drdy[i] = exp_rdy[2*i];
      exp_ardy[i] = exp_rdy[2*i+1];
    end
    mst = w / 2;
    rd  = (w % 2) == 1;
    exp_add = '0;
    exp_din = '0;
    if (wv) begin
      exp_add = rd ? DMX_MTOO_ADD_ADD[mst*AW +: AW] : DMX_MTOO_DAT_ADD[mst*AW +: AW];
      if (!rd) exp_din = DMX_MTOO_DAT_DAT[mst*DW +: DW];
    end
    check_val({name, ".dat_rdy"}, 64'(DMX_MTOO_DAT_RDY), 64'(exp_drdy));
    check_val({name, ".add_rdy"}, 64'(DMX_MTOO_ADD_RDY), 64'(exp_ardy));
    check_val({name, ".cen"}, 64'(SRAM_CEN), 64'(!wv));
    check_val({name, ".wen"}, 64'(SRAM_WEN), 64'(!(wv && !rd)));
    check_val({name, ".sram_add"}, 64'(SRAM_ADD), 64'(exp_add));
    check_val({name, ".sram_din"}, 64'(SRAM_DIN), 64'(exp_din));
    exp_ovld = '0;
    exp_olst = '0;
    if (occ > 0) begin
      exp_ovld[m_q[0].tag] = 1'b1;
      exp_olst[m_q[0].tag] = m_q[0].lst;
      for (int i = 0; i < N; i++) exp_odat[i*DW +: DW] = m_q[0].dat;
      check_val({name, ".otom_dat"}, 64'(DMX_OTOM_DAT_DAT), 64'(exp_odat));
    end
    check_val({name, ".otom_vld"}, 64'(DMX_OTOM_DAT_VLD), 64'(exp_ovld));
    check_val({name, ".otom_lst"}, 64'(DMX_OTOM_DAT_LST), 64'(exp_olst));

    if (deq) void'(m_q.pop_front());
    if (m_pend) m_q.push_back('{tag: m_ptag, lst: m_plst, dat: m_pdat});
    m_pend = 0;
    if (wv) begin
      if (rd) begin
        m_pend = 1; m_ptag = mst; m_plst = l[w]; m_pdat = mem[exp_add];
      end else begin
        mem[exp_add] = exp_din;
      end
      if (!m_lock) begin
        m_ptr = (w + 1) % NS;
        if (!l[w]) begin m_lock = 1; m_lsrc = w; end
      end else if (l[w]) begin
        m_lock = 0;
      end
    end
    @(posedge clk);
    #1;
    SRAM_DOUT = m_pend ? m_pdat : DW'($urandom);
  endtask

  task automatic check_reset_outputs(input string name);
    check_val({name, ".dat_rdy"}, 64'(DMX_MTOO_DAT_RDY), 64'd0);
    check_val({name, ".add_rdy"}, 64'(DMX_MTOO_ADD_RDY), 64'd0);
    check_val({name, ".otom_vld"}, 64'(DMX_OTOM_DAT_VLD), 64'd0);
    check_val({name, ".otom_lst"}, 64'(DMX_OTOM_DAT_LST), 64'd0);
    check_val({name, ".otom_dat"}, 64'(DMX_OTOM_DAT_DAT), 64'd0);
    check_val({name, ".cen_wen"}, 64'({SRAM_CEN, SRAM_WEN}), 64'd3);
    check_val({name, ".add_din"}, 64'({SRAM_ADD, SRAM_DIN}), 64'd0);
  endtask

  // Entered at posedge+1; reset asserts mid-cycle, releases one cycle later away from the edge.
  task automatic pulse_reset(input string name);
    rst_n = 1'b0;
    #3;
    check_reset_outputs(name);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = DW'($urandom);
    rst_n = 1'b0;
    clear_inputs();
    DMX_OTOM_DAT_RDY = '1;
    SRAM_DOUT = '0;
    DMX_MTOO_DAT_VLD = 4'b1111;
    DMX_MTOO_ADD_VLD = 4'b1111;
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    clear_inputs();

    // Write m0 then read it back through m2
    DMX_MTOO_DAT_VLD = 4'b0001; DMX_MTOO_DAT_LST = 4'b0001;
    DMX_MTOO_DAT_ADD[AW-1:0] = 10'h005; DMX_MTOO_DAT_DAT[DW-1:0] = 4'hA;
    step("wr_m0");
    clear_inputs();
    DMX_MTOO_ADD_VLD = 4'b0100; DMX_MTOO_ADD_LST = 4'b0100;
    DMX_MTOO_ADD_ADD[2*AW +: AW] = 10'h005;
    step("rd_m2");
    clear_inputs();
    repeat (3) step("rd_m2_ret");

    // Idle bank after reset, then m1 write valid with ptr=0
    pulse_reset("rst_a");
    step("idle");
    DMX_MTOO_DAT_VLD = 4'b0010; DMX_MTOO_DAT_LST = 4'b0010;
    step("m1_vld");
    clear_inputs();

    // Round-robin among m0, m1, m3 single-beat writes
    DMX_MTOO_DAT_VLD = 4'b1011; DMX_MTOO_DAT_LST = 4'b1011;
    repeat (6) step("rr");
    clear_inputs();

    // m1 4-beat burst with m2 write valid throughout
    DMX_MTOO_DAT_VLD = 4'b0110;
    for (int b = 0; b < 5; b++) begin
      DMX_MTOO_DAT_LST = (b == 3) ? 4'b0110 : 4'b0100;
      if (b == 4) DMX_MTOO_DAT_VLD = 4'b0100;
      step("burst");
    end
    clear_inputs();

    // Back-to-back reads with return blocked, then drain
    DMX_OTOM_DAT_RDY = '0;
    DMX_MTOO_ADD_VLD = 4'b0001; DMX_MTOO_ADD_LST = 4'b0001;
    for (int a = 0; a < 3; a++) begin
      DMX_MTOO_ADD_ADD[AW-1:0] = AW'(a + 1);
      step("rd_stall");
    end
    clear_inputs();
    step("rd_full");
    DMX_OTOM_DAT_RDY = '1;
    repeat (4) step("rd_drain");

    // Reset mid-burst with two reads buffered
    DMX_OTOM_DAT_RDY = '0;
    DMX_MTOO_ADD_VLD = 4'b0001; DMX_MTOO_ADD_LST = 4'b0001;
    repeat (2) step("pre_rst_rd");
    clear_inputs();
    DMX_MTOO_DAT_VLD = 4'b0010;
    step("pre_rst_burst");
    step("pre_rst_full");
    pulse_reset("rst_b");
    clear_inputs();
    DMX_OTOM_DAT_RDY = '1;
    step("post_rst");

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 999) begin
        pulse_reset("rst_rand");
      end else begin
        rand_inputs((c < 1500) ? 75 : 100);
        step("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
